beat_scheduler: RTL

Sequences one play round of the rhythm game. It issues timed circle-spawn events into 4 shared on-screen circle slots, ages each live circle by frame, and resolves player hits and expiries (misses) into a saturating health value. It sits between the top-level screen FSM, which drives start/abort and consumes done/pass, and the circle sprite/hit-detect datapath, which consumes spawn/slot info and supplies hit pulses.

---
 rtl/beat_scheduler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/beat_scheduler.sv
// Round sequencer for the rhythm game: spawns circles into 4 shared slots on a
// frame-tick schedule, ages them, and folds hits and misses into health.
module beat_scheduler #(
  parameter int NUM_BEATS     = 4,
  parameter int BEAT_INTERVAL = 30,
  parameter int LIFETIME      = 90,
  parameter int HEALTH_MAX    = 8,
  parameter int PASS_HEALTH   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       abort,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic [1:0] hit_slot,
  output logic       spawn,
  output logic [1:0] spawn_slot,
  output logic [1:0] circletype,
  output logic [3:0] slot_active,
  output logic [3:0] health,
  output logic [3:0] hits,
  output logic [3:0] misses,
  output logic       busy,
  output logic       done,
  output logic       pass
);

  localparam int IW = (BEAT_INTERVAL > 1) ? $clog2(BEAT_INTERVAL) : 1;
  localparam logic [IW-1:0] INTERVAL_RELOAD = IW'(BEAT_INTERVAL - 1);
  localparam logic [7:0]    LIFE_INIT       = 8'(LIFETIME);
  localparam logic [4:0]    LAST_BEAT       = 5'(NUM_BEATS - 1);
  localparam logic [3:0]    HEALTH_INIT     = 4'(HEALTH_MAX);
  localparam logic [3:0]    PASS_LEVEL      = 4'(PASS_HEALTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      beat_idx_q, beat_idx_d;
  logic [IW-1:0]   interval_q, interval_d;
  logic [3:0][7:0] life_q, life_d;
  logic [3:0]      slot_active_q, slot_active_d;
  logic [3:0]      health_q, health_d;
  logic [3:0]      hits_q, hits_d;
  logic [3:0]      misses_q, misses_d;
  logic            spawn_q, spawn_d;
  logic [1:0]      spawn_slot_q, spawn_slot_d;
  logic [1:0]      circletype_q, circletype_d;
  logic            pass_q, pass_d;

  logic              playing, attempt, last_attempt, slot_free, hit_cnt;
  logic [1:0]        free_slot;
  logic [3:0]        hit_vec, expire_vec, miss_vec, alloc_vec;
  logic [2:0]        miss_cnt;
  logic [4:0]        hits_sum, misses_sum;
  logic signed [5:0] health_sum;
  logic [3:0]        health_clamped;

  assign playing      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign attempt      = (state_q == S_RUN) && frame_tick && (interval_q == '0);
  assign last_attempt = attempt && (beat_idx_q == LAST_BEAT);

  // Allocation looks only at the registered flags, so a slot freed this cycle stays unused.
  always_comb begin
    free_slot = 2'd0;
    slot_free = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!slot_active_q[i]) begin
        free_slot = 2'(i);
        slot_free = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign hit_vec[gi]    = playing & hit & (hit_slot == 2'(gi)) & slot_active_q[gi];
    assign expire_vec[gi] = playing & frame_tick & slot_active_q[gi] & (life_q[gi] == 8'd1);
    assign miss_vec[gi]   = expire_vec[gi] & ~hit_vec[gi];
    assign alloc_vec[gi]  = attempt & slot_free & (free_slot == 2'(gi));
  end

  assign hit_cnt = |hit_vec;

  always_comb begin
    miss_cnt = {2'b00, attempt & ~slot_free};
    for (int i = 0; i < 4; i++) begin
      miss_cnt = miss_cnt + {2'b00, miss_vec[i]};
    end
  end

  assign hits_sum   = {1'b0, hits_q} + {4'b0000, hit_cnt};
  assign misses_sum = {1'b0, misses_q} + {2'b00, miss_cnt};
  assign health_sum = $signed({2'b00, health_q}) + $signed({5'b00000, hit_cnt})
                    - $signed({3'b000, miss_cnt});

  always_comb begin
    if (health_sum < 6'sd0) begin
      health_clamped = 4'd0;
    end else if (health_sum > $signed({2'b00, HEALTH_INIT})) begin
      health_clamped = HEALTH_INIT;
    end else begin
      health_clamped = health_sum[3:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_idx_d    = beat_idx_q;
    interval_d    = interval_q;
    life_d        = life_q;
    slot_active_d = slot_active_q;
    health_d      = health_q;
    hits_d        = hits_q;
    misses_d      = misses_q;
    spawn_d       = 1'b0;
    spawn_slot_d  = spawn_slot_q;
    circletype_d  = circletype_q;
    pass_d        = pass_q;

    if (abort && state_q != S_IDLE) begin
      state_d       = S_IDLE;
      slot_active_d = 4'b0000;
      pass_d        = 1'b0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d       = S_RUN;
      beat_idx_d    = 5'd0;
      interval_d    = '0;
      health_d      = HEALTH_INIT;
      hits_d        = 4'd0;
      misses_d      = 4'd0;
      slot_active_d = 4'b0000;
      pass_d        = 1'b0;
    end else if (playing) begin
      slot_active_d = (slot_active_q & ~hit_vec & ~expire_vec) | alloc_vec;
      for (int i = 0; i < 4; i++) begin
        if (alloc_vec[i]) begin
          life_d[i] = LIFE_INIT;
        end else if (frame_tick && slot_active_q[i]) begin
          life_d[i] = life_q[i] - 8'd1;
        end
      end
      hits_d   = hits_sum[4] ? 4'd15 : hits_sum[3:0];
      misses_d = misses_sum[4] ? 4'd15 : misses_sum[3:0];
      health_d = health_clamped;
      if (attempt && slot_free) begin
        spawn_d      = 1'b1;
        spawn_slot_d = free_slot;
        circletype_d = beat_idx_q[1:0];
      end
      if (attempt) begin
        beat_idx_d = beat_idx_q + 5'd1;
        interval_d = INTERVAL_RELOAD;
      end else if (state_q == S_RUN && frame_tick) begin
        interval_d = interval_q - 1'b1;
      end
      if (health_clamped == 4'd0) begin
        state_d       = S_DONE;
        pass_d        = 1'b0;
        slot_active_d = 4'b0000;
      end else if (last_attempt) begin
        state_d = S_DRAIN;
      end else if (state_q == S_DRAIN && slot_active_q == 4'b0000) begin
        state_d = S_DONE;
        pass_d  = (health_q >= PASS_LEVEL);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      beat_idx_q    <= 5'd0;
      interval_q    <= '0;
      life_q        <= '0;
      slot_active_q <= 4'b0000;
      health_q      <= HEALTH_INIT;
      hits_q        <= 4'd0;
      misses_q      <= 4'd0;
      spawn_q       <= 1'b0;
      spawn_slot_q  <= 2'd0;
      circletype_q  <= 2'd0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_idx_q    <= beat_idx_d;
      interval_q    <= interval_d;
      life_q        <= life_d;
      slot_active_q <= slot_active_d;
      health_q      <= health_d;
      hits_q        <= hits_d;
      misses_q      <= misses_d;
      spawn_q       <= spawn_d;
      spawn_slot_q  <= spawn_slot_d;
      circletype_q  <= circletype_d;
      pass_q        <= pass_d;
    end
  end

  assign spawn       = spawn_q;
  assign spawn_slot  = spawn_slot_q;
  assign circletype  = circletype_q;
  assign slot_active = slot_active_q;
  assign health      = health_q;
  assign hits        = hits_q;
  assign misses      = misses_q;
  assign busy        = playing;
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;

endmodule
